// File: rtl/cache_wb_lru_if.sv
// Core-side request/response and word-serial memory port of cache_wb_lru.
// Handshakes: the core holds req_* until hit=1; a memory word moves on any cycle with mem_req && mem_ready.
interface cache_wb_lru_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        hit;
    logic [31:0] rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, mem_ready, mem_rdata,
        output hit, rdata, busy, mem_req, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, mem_ready, mem_rdata,
        input  hit, rdata, busy, mem_req, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_wb_lru.sv
// Set-associative write-back data cache with true-LRU ages, byte-enable stores,
// same-cycle hit path and a one-word-per-handshake miss engine.
module cache_wb_lru #(
    parameter int INDEX_SIZE        = 2,
    parameter int BLOCK_OFFSET_SIZE = 4,
    parameter int WAYS              = 2,
    localparam int LRU_W            = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    cache_wb_lru_if.slave      bus,
    output logic [1:0]         state_dbg_o
);
    localparam int SETS   = 1 << INDEX_SIZE;
    localparam int WORDS  = 1 << (BLOCK_OFFSET_SIZE - 2);
    localparam int CNT_W  = (BLOCK_OFFSET_SIZE > 2) ? BLOCK_OFFSET_SIZE - 2 : 1;
    localparam int TAG_W  = 32 - INDEX_SIZE - BLOCK_OFFSET_SIZE;
    localparam int WAY_W  = LRU_W;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_DONE} state_e;

    logic [31:0]           data_q  [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
    logic                  valid_q [WAYS][SETS];
    logic                  dirty_q [WAYS][SETS];
    logic [LRU_W-1:0]      age_q   [WAYS][SETS];

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
    logic [INDEX_SIZE-1:0] miss_idx_q, miss_idx_d;
    logic [WAY_W-1:0]      victim_q, victim_d;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_SIZE-1:0] req_idx;
    logic [CNT_W-1:0]      req_word;
    logic                  hit_any, hit_w, inv_any, cnt_last;
    logic [WAY_W-1:0]      hit_way, inv_way, old_way, victim_sel;
    logic                  wb_last, fill_word, fill_last;
    logic                  lru_en;
    logic [INDEX_SIZE-1:0] lru_idx;
    logic [WAY_W-1:0]      lru_way;
    logic [LRU_W-1:0]      lru_old;
    logic                  mem_req_w, mem_write_w;
    logic [31:0]           mem_addr_w, mem_wdata_w;

    assign req_tag  = bus.req_addr[31 -: TAG_W];
    assign req_idx  = bus.req_addr[BLOCK_OFFSET_SIZE +: INDEX_SIZE];
    assign req_word = CNT_W'((bus.req_addr >> 2) & 32'(WORDS - 1));
    assign cnt_last = (cnt_q == CNT_W'(WORDS - 1));

    // Tag lookup and victim choice: lowest invalid way first, otherwise the oldest age.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        old_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[w][req_idx] == LRU_W'(WAYS - 1)) old_way = WAY_W'(w);
        end
        victim_sel = inv_any ? inv_way : old_way;
    end

    assign hit_w     = bus.req_valid && (state_q == S_IDLE) && hit_any;
    assign wb_last   = (state_q == S_WB) && bus.mem_ready && cnt_last;
    assign fill_word = (state_q == S_REFILL) && bus.mem_ready;
    assign fill_last = fill_word && cnt_last;

    // A refilled line replaces the oldest slot, so it ages every other way below the top.
    assign lru_en  = hit_w || fill_last;
    assign lru_idx = hit_w ? req_idx : miss_idx_q;
    assign lru_way = hit_w ? hit_way : victim_q;
    assign lru_old = hit_w ? age_q[hit_way][req_idx] : LRU_W'(WAYS - 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        victim_d    = victim_q;
        mem_req_w   = 1'b0;
        mem_write_w = 1'b0;
        mem_addr_w  = '0;
        mem_wdata_w = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !hit_any) begin
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    victim_d   = victim_sel;
                    cnt_d      = '0;
                    state_d    = (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
                                 ? S_WB : S_REFILL;
                end
            end
            S_WB: begin
                mem_req_w   = 1'b1;
                mem_write_w = 1'b1;
                mem_addr_w  = {tag_q[victim_q][miss_idx_q], miss_idx_q, {BLOCK_OFFSET_SIZE{1'b0}}}
                              | (32'(cnt_q) << 2);
                mem_wdata_w = data_q[victim_q][miss_idx_q][cnt_q];
                if (bus.mem_ready) begin
                    cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                    if (cnt_last) state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req_w  = 1'b1;
                mem_addr_w = {miss_tag_q, miss_idx_q, {BLOCK_OFFSET_SIZE{1'b0}}} | (32'(cnt_q) << 2);
                if (bus.mem_ready) begin
                    cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                    if (cnt_last) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line storage carries no reset; validity alone decides whether contents are used.
    always_ff @(posedge clk) begin
        if (hit_w && bus.req_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_be[i]) data_q[hit_way][req_idx][req_word][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
        if (fill_word) data_q[victim_q][miss_idx_q][cnt_q] <= bus.mem_rdata;
        if (fill_last) tag_q[victim_q][miss_idx_q] <= miss_tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            victim_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            victim_q   <= victim_d;
            if (hit_w && bus.req_write) dirty_q[hit_way][req_idx] <= 1'b1;
            if (wb_last) begin
                valid_q[victim_q][miss_idx_q] <= 1'b0;
                dirty_q[victim_q][miss_idx_q] <= 1'b0;
            end
            if (fill_last) begin
                valid_q[victim_q][miss_idx_q] <= 1'b1;
                dirty_q[victim_q][miss_idx_q] <= 1'b0;
            end
            if (lru_en) begin
                for (int j = 0; j < WAYS; j++) begin
                    if (WAY_W'(j) == lru_way) age_q[j][lru_idx] <= '0;
                    else if (age_q[j][lru_idx] < lru_old) age_q[j][lru_idx] <= age_q[j][lru_idx] + LRU_W'(1);
                end
            end
        end
    end

    assign bus.hit       = hit_w;
    assign bus.rdata     = hit_w ? data_q[hit_way][req_idx][req_word] : 32'h0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_req   = mem_req_w;
    assign bus.mem_write = mem_write_w;
    assign bus.mem_addr  = mem_addr_w;
    assign bus.mem_wdata = mem_wdata_w;
    assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_cache_wb_lru.sv
// Directed bench for cache_wb_lru: the memory returns word address + 0x1000_0000,
// and every write-back word is checked against hand-computed line contents.
module tb_cache_wb_lru;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    cache_wb_lru_if bus ();

    cache_wb_lru dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .state_dbg_o (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
    endtask

    // Single-cycle access expected to hit with no memory traffic.
    task automatic hit_access(input string tag, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp);
        @(negedge clk);
        drive_req(w, a, d, be);
        #1;
        check($sformatf("%s_hit", tag), 32'(bus.hit), 32'd1);
        check($sformatf("%s_memreq", tag), 32'(bus.mem_req), 32'd0);
        if (!w) check($sformatf("%s_rdata", tag), bus.rdata, exp);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // One memory word: wait for the request, hold mem_ready low for `stall` cycles, then complete it.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int stall);
        int n = 0;
        @(negedge clk);
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_req", tag), 32'(bus.mem_req), 32'd1);
        check($sformatf("%s_wr", tag), 32'(bus.mem_write), 32'(w));
        check($sformatf("%s_addr", tag), bus.mem_addr, a);
        if (w) check($sformatf("%s_wdata", tag), bus.mem_wdata, d);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check($sformatf("%s_hold_req", tag), 32'(bus.mem_req), 32'd1);
            check($sformatf("%s_hold_wr", tag), 32'(bus.mem_write), 32'(w));
            check($sformatf("%s_hold_addr", tag), bus.mem_addr, a);
            if (w) check($sformatf("%s_hold_wdata", tag), bus.mem_wdata, d);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = a + 32'h1000_0000;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // Load that misses: optional 4-word write-back, 4-word refill, DONE, then the hit.
    task automatic miss_load(input string tag, input logic [31:0] a, input logic dirty,
                             input logic [31:0] wb_base, input logic [3:0][31:0] wbd, input int stall);
        logic [31:0] line;
        line = a & ~32'hF;
        @(negedge clk);
        drive_req(1'b0, a, '0, '0);
        #1;
        check($sformatf("%s_miss", tag), 32'(bus.hit), 32'd0);
        check($sformatf("%s_busy0", tag), 32'(bus.busy), 32'd0);
        if (dirty) begin
            for (int i = 0; i < 4; i++) xfer($sformatf("%s_wb%0d", tag, i), 1'b1, wb_base + 32'(4*i), wbd[i], stall);
        end
        for (int i = 0; i < 4; i++) xfer($sformatf("%s_rd%0d", tag, i), 1'b0, line + 32'(4*i), '0, stall);
        @(negedge clk);
        check($sformatf("%s_done_hit", tag), 32'(bus.hit), 32'd0);
        check($sformatf("%s_done_busy", tag), 32'(bus.busy), 32'd1);
        check($sformatf("%s_done_req", tag), 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        check($sformatf("%s_hit", tag), 32'(bus.hit), 32'd1);
        check($sformatf("%s_busy", tag), 32'(bus.busy), 32'd0);
        check($sformatf("%s_rdata", tag), bus.rdata, a + 32'h1000_0000);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_memreq", 32'(bus.mem_req), 32'd0);
        check("rst_memwr", 32'(bus.mem_write), 32'd0);
        check("rst_memaddr", bus.mem_addr, 32'h0);
        check("rst_memwdata", bus.mem_wdata, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;

        // Clean fill of 0x40 into way 0, then a partial store and read-back.
        miss_load("ld40", 32'h40, 1'b0, '0, '0, 0);
        hit_access("st44", 1'b1, 32'h44, 32'hAABB_CCDD, 4'b0110, '0);
        hit_access("ld44", 1'b0, 32'h44, '0, '0, 32'h10BB_CC44);

        // 0x000 lands in the free way; touching it leaves dirty 0x040 as LRU.
        miss_load("ld00", 32'h00, 1'b0, '0, '0, 0);
        hit_access("ld00b", 1'b0, 32'h00, '0, '0, 32'h1000_0000);
        miss_load("ld0c0", 32'hC0, 1'b1, 32'h40,
                  {32'h1000_004C, 32'h1000_0048, 32'h10BB_CC44, 32'h1000_0040}, 0);
        hit_access("ld00c", 1'b0, 32'h00, '0, '0, 32'h1000_0000);

        // Stalled memory: 0x0C0 is now LRU and clean, replaced by 0x080.
        miss_load("ld080", 32'h80, 1'b0, '0, '0, 3);
        hit_access("ld00d", 1'b0, 32'h00, '0, '0, 32'h1000_0000);

        // Reset in the middle of refilling 0x0C0.
        @(negedge clk);
        drive_req(1'b0, 32'hC0, '0, '0);
        #1;
        check("rstmid_miss", 32'(bus.hit), 32'd0);
        xfer("rstmid_rd0", 1'b0, 32'hC0, '0, 0);
        xfer("rstmid_rd1", 1'b0, 32'hC4, '0, 0);
        @(negedge clk);
        check("rstmid_req", 32'(bus.mem_req), 32'd1);
        check("rstmid_addr", bus.mem_addr, 32'hC8);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_after_req", 32'(bus.mem_req), 32'd0);
        check("rstmid_after_busy", 32'(bus.busy), 32'd0);
        check("rstmid_after_hit", 32'(bus.hit), 32'd0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        miss_load("ld0c0r", 32'hC0, 1'b0, '0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
